// File: rtl/count_capture_pkg.sv
// Shared types and sizing helpers for the timestamp capture block.
package count_capture_pkg;

    typedef logic [1:0] src_t;  // {cmp_hit, strobe_hit}

    function automatic int entry_w(input int wrapw, input int width);
        return wrapw + width + $bits(src_t);
    endfunction

endpackage

// File: rtl/cap_fifo.sv
// Generic synchronous FIFO; pointers carry an extra MSB so full and empty differ.
module cap_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr, rptr;
    logic         do_push, do_pop;

    assign level = LW'(wptr - rptr);
    assign empty = (wptr == rptr);
    assign full  = (level == LW'(DEPTH));
    assign dout  = mem[rptr[AW-1:0]];

    // A push into a full FIFO lands in the slot the head is leaving this cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/count_capture.sv
// Captures {wrap count, counter value} on a strobe or compare match and queues
// the timestamps for a valid/ready consumer.
module count_capture
    import count_capture_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int WRAPW = 8,
    parameter int DEPTH = 4,
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       value,
    input  logic                   capture,
    input  logic                   cmp_en,
    input  logic [WIDTH-1:0]       cmp_val,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WRAPW+WIDTH-1:0] out_data,
    output src_t                   out_src,
    output logic [LW-1:0]          level,
    output logic                   overflow,
    input  logic                   clr_ovf
);

    localparam int EW = entry_w(WRAPW, WIDTH);

    logic [WIDTH-1:0] prev;
    logic             prev_vld;
    logic [WRAPW-1:0] wrap_cnt, wrap_cnt_next;
    logic             match_d;
    logic             wrap, eq, hit_c, ev, pop, drop, full, empty;
    src_t             src;
    logic [EW-1:0]    entry, head;

    // Only a clean all-ones to zero step counts; reloads are ignored.
    assign wrap          = prev_vld && (prev == '1) && (value == '0);
    assign wrap_cnt_next = wrap_cnt + WRAPW'(wrap);

    assign eq    = (value == cmp_val);
    assign hit_c = cmp_en && eq && !match_d;
    assign src   = {hit_c, capture};
    assign ev    = |src;
    assign entry = {wrap_cnt_next, value, src};

    assign pop  = out_valid && out_ready;
    assign drop = ev && full && !pop;

    cap_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ev && !rst),
        .din   (entry),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign out_valid = !empty;
    assign out_data  = head[EW-1:$bits(src_t)];
    assign out_src   = head[$bits(src_t)-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            prev     <= '0;
            prev_vld <= 1'b0;
            wrap_cnt <= '0;
            match_d  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            prev     <= value;
            prev_vld <= 1'b1;
            wrap_cnt <= wrap_cnt_next;
            match_d  <= eq;
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_count_capture.sv
// Directed and randomized checks of count_capture against a queue-based model.
module tb_count_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic        capture = 1'b0;
    logic        cmp_en = 1'b0;
    logic [15:0] cmp_val = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] out_data;
    logic [1:0]  out_src;
    logic [2:0]  level;
    logic        overflow;
    logic        clr_ovf = 1'b0;

    count_capture #(.WIDTH(16), .WRAPW(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .value(value), .capture(capture),
        .cmp_en(cmp_en), .cmp_val(cmp_val), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_src(out_src),
        .level(level), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // Reference model: timestamps as integers, FIFO as a queue.
    logic [25:0] q[$];
    int          m_wrap = 0;
    int          m_prev = 0;
    bit          m_prev_vld = 0;
    bit          m_last_eq = 0;
    bit          m_ovf = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit          is_wrap, eq, hit, ev, pop, was_full;
        int          wrap_next;
        logic [25:0] e;
        if (rst) begin
            q.delete();
            m_wrap = 0; m_prev = 0; m_prev_vld = 0; m_last_eq = 0; m_ovf = 0;
            return;
        end
        is_wrap   = m_prev_vld && m_prev == 65535 && value == 0;
        wrap_next = (m_wrap + (is_wrap ? 1 : 0)) % 256;
        eq        = (value == cmp_val);
        hit       = cmp_en && eq && !m_last_eq;
        ev        = capture || hit;
        was_full  = (q.size() == 4);
        pop       = (q.size() > 0) && out_ready;
        if (pop) void'(q.pop_front());
        if (ev) begin
            if (was_full && !pop) m_ovf = 1;
            else begin
                e = {wrap_next[7:0], value, hit, capture};
                q.push_back(e);
            end
        end
        if (!(ev && was_full && !pop) && clr_ovf) m_ovf = 0;
        m_wrap = wrap_next;
        m_prev = value;
        m_prev_vld = 1;
        m_last_eq = eq;
    endtask

    task automatic step(input logic [15:0] v, input bit cap, input bit rdy, input bit clr, input bit r);
        value = v; capture = cap; out_ready = rdy; clr_ovf = clr; rst = r;
        model_step();
        @(posedge clk);
        #1;
        chk("valid", 32'(out_valid), 32'(q.size() != 0));
        chk("level", 32'(level), 32'(q.size()));
        chk("ovf", 32'(overflow), 32'(m_ovf));
        if (q.size() != 0) begin
            chk("data", 32'(out_data), 32'(q[0][25:2]));
            chk("src", 32'(out_src), 32'(q[0][1:0]));
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) step(value + 16'd1, 0, 1, 0, 0);
    endtask

    initial begin
        logic [15:0] v;
        int          r;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("rst_level", 32'(level), 0);
        chk("rst_valid", 32'(out_valid), 0);

        // 1: strobe capture at 105
        for (int i = 100; i <= 110; i++) begin
            step(16'(i), i == 105, 0, 0, 0);
            if (i == 104) chk("t1_pre_valid", 32'(out_valid), 0);
            if (i == 105) begin
                chk("t1_valid", 32'(out_valid), 1);
                chk("t1_data", 32'(out_data), 32'h000069);
                chk("t1_src", 32'(out_src), 1);
            end
        end
        drain();

        // 2: held compare value fires once
        cmp_en = 1; cmp_val = 7;
        for (int i = 0; i < 3; i++) step(7, 0, 0, 0, 0);
        chk("t2_level", 32'(level), 1);
        chk("t2_data", 32'(out_data), 32'h000007);
        chk("t2_src", 32'(out_src), 2);
        cmp_en = 0;
        drain();

        // 3: rollover extends timestamp, reload does not
        step(16'hFFFE, 0, 0, 0, 0);
        step(16'hFFFF, 0, 0, 0, 0);
        step(16'h0000, 1, 0, 0, 0);
        chk("t3_wrap_data", 32'(out_data), 32'h010000);
        step(16'h0001, 0, 1, 0, 0);
        step(50, 0, 0, 0, 0);
        step(2, 1, 0, 0, 0);
        chk("t3_reload_data", 32'(out_data), 32'h010002);
        drain();

        // 4: strobe and compare together
        cmp_en = 1; cmp_val = 20;
        step(19, 0, 0, 0, 0);
        step(20, 1, 0, 0, 0);
        chk("t4_level", 32'(level), 1);
        chk("t4_src", 32'(out_src), 3);
        chk("t4_data", 32'(out_data), 32'h010014);
        cmp_en = 0;
        drain();

        // 5: overflow, push while popping when full, clear, clear vs drop
        for (int i = 30; i < 35; i++) step(16'(i), 1, 0, 0, 0);
        chk("t5_full", 32'(level), 4);
        chk("t5_ovf", 32'(overflow), 1);
        step(35, 1, 1, 0, 0);
        chk("t5_pushpop_level", 32'(level), 4);
        chk("t5_pushpop_head", 32'(out_data), 32'h01001F);
        step(36, 0, 0, 1, 0);
        chk("t5_clr", 32'(overflow), 0);
        step(37, 1, 0, 1, 0);
        chk("t5_set_beats_clr", 32'(overflow), 1);

        // 6: reset mid-operation with a simultaneous capture
        step(38, 0, 1, 0, 0);
        chk("t6_pre_level", 32'(level), 3);
        step(39, 1, 0, 0, 1);
        chk("t6_level", 32'(level), 0);
        chk("t6_valid", 32'(out_valid), 0);
        chk("t6_ovf", 32'(overflow), 0);
        step(40, 1, 0, 0, 0);
        chk("t6_wrap_cleared", 32'(out_data), 32'h000028);
        drain();

        // Randomized traffic
        v = 16'hFFF0;
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6) v = v + 16'd1;
            else if (r == 6) v = 16'hFFFD + 16'($urandom_range(0, 2));
            else v = 16'($urandom_range(0, 40));
            if ($urandom_range(0, 7) == 0) cmp_val = 16'($urandom_range(0, 40));
            cmp_en = ($urandom_range(0, 3) != 0);
            step(v, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
